// File: rtl/jtframe_pocket_slot.sv
// Pocket scaler-slot scheduler: arbitrates menu/core slot requests and injects the slot command
// word on one blanking pixel after VS. Optional per-frame resend: JTFRAME_POCKET_SLOT_REPEAT_EN.
module jtframe_pocket_slot #(
  parameter int unsigned BLANK_DLY = 2,
  parameter logic [2:0]  DEF_SLOT  = 3'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_cen,
  input  logic [23:0] vid_rgb,
  input  logic        vid_vs,
  input  logic        vid_hs,
  input  logic        vid_de,
  input  logic        menu_req,
  input  logic [2:0]  menu_slot,
  input  logic        core_req,
  input  logic [2:0]  core_slot,
  output logic        menu_ack,
  output logic        core_ack,
  output logic [23:0] pck_rgb,
  output logic        pck_vs,
  output logic        pck_hs,
  output logic        pck_de,
  output logic [2:0]  cur_slot,
  output logic        busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RGB_W  = 24;
  localparam int unsigned SLOT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_WAIT_BLANK,
    ST_SEND,
    ST_HOLD
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MENU,
    GNT_CORE,
    GNT_SELF
  } gnt_t;

  state_t              state_q, state_d;
  gnt_t                gnt_q, gnt_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
  logic                menu_ack_q, menu_ack_d;
  logic                core_ack_q, core_ack_d;
  logic [RGB_W-1:0]    rgb_q, rgb_d;
  logic                vs_q, vs_d;
  logic                hs_q, hs_d;
  logic                de_q, de_d;
  logic                busy_q, busy_d;

  logic                gnt_req_c;
  logic [CNT_W-1:0]    cnt_inc_c;

  // Self-grants have no requester to drop, so they can never be cancelled
  always_comb begin
    gnt_req_c = 1'b1;
    case (gnt_q)
      GNT_MENU: gnt_req_c = menu_req;
      GNT_CORE: gnt_req_c = core_req;
      default:  gnt_req_c = 1'b1;
    endcase
    cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    cur_slot_d = cur_slot_q;
    menu_ack_d = 1'b0;
    core_ack_d = 1'b0;
    rgb_d      = vid_rgb;
    vs_d       = vid_vs;
    hs_d       = vid_hs;
    de_d       = vid_de;

    case (state_q)
      ST_IDLE: begin
        if (menu_req) begin
          gnt_d   = GNT_MENU;
          slot_d  = menu_slot;
          state_d = ST_WAIT_VS;
        end else if (core_req) begin
          gnt_d   = GNT_CORE;
          slot_d  = core_slot;
          state_d = ST_WAIT_VS;
        end
`ifdef JTFRAME_POCKET_SLOT_REPEAT_EN
        else if (pix_cen && vid_vs) begin
          gnt_d   = GNT_SELF;
          slot_d  = cur_slot_q;
          cnt_d   = '0;
          state_d = ST_WAIT_BLANK;
        end
`endif
      end
      ST_WAIT_VS: begin
        if (!gnt_req_c) begin
          gnt_d   = GNT_NONE;
          state_d = ST_IDLE;
        end else if (pix_cen && vid_vs) begin
          cnt_d   = '0;
          state_d = ST_WAIT_BLANK;
        end
      end
      ST_WAIT_BLANK: begin
        if (!gnt_req_c) begin
          gnt_d   = GNT_NONE;
          state_d = ST_IDLE;
        end else if (pix_cen) begin
          if (vid_vs) begin
            cnt_d = '0;
          end else if (vid_de) begin
            state_d = ST_WAIT_VS;
          end else begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(BLANK_DLY)) state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (pix_cen) begin
          if (!vid_de) begin
            rgb_d      = {13'd0, slot_q, 8'd0};
            de_d       = 1'b0;
            cur_slot_d = slot_q;
            menu_ack_d = (gnt_q == GNT_MENU);
            core_ack_d = (gnt_q == GNT_CORE);
            state_d    = ST_HOLD;
          end else begin
            state_d = ST_WAIT_VS;
          end
        end
      end
      ST_HOLD: begin
        // Command word stays on the bus for the whole pixel period
        if (pix_cen) begin
          gnt_d   = GNT_NONE;
          state_d = ST_IDLE;
        end else begin
          rgb_d = rgb_q;
          de_d  = 1'b0;
        end
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_NONE;
      slot_q     <= '0;
      cnt_q      <= '0;
      cur_slot_q <= DEF_SLOT;
      menu_ack_q <= 1'b0;
      core_ack_q <= 1'b0;
      rgb_q      <= '0;
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      de_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      cur_slot_q <= cur_slot_d;
      menu_ack_q <= menu_ack_d;
      core_ack_q <= core_ack_d;
      rgb_q      <= rgb_d;
      vs_q       <= vs_d;
      hs_q       <= hs_d;
      de_q       <= de_d;
      busy_q     <= busy_d;
    end
  end

  assign menu_ack = menu_ack_q;
  assign core_ack = core_ack_q;
  assign pck_rgb  = rgb_q;
  assign pck_vs   = vs_q;
  assign pck_hs   = hs_q;
  assign pck_de   = de_q;
  assign cur_slot = cur_slot_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_jtframe_pocket_slot.sv
// Directed scoreboard bench for jtframe_pocket_slot; each pixel is one pix_cen clk plus one idle clk.
module tb_jtframe_pocket_slot;

  localparam int unsigned BLANK_DLY = 2;
  localparam logic [2:0]  DEF_SLOT  = 3'd0;
`ifdef JTFRAME_POCKET_SLOT_REPEAT_EN
  localparam int IDLE_K = 3;
`else
  localparam int IDLE_K = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_cen;
  logic [23:0] vid_rgb;
  logic        vid_vs, vid_hs, vid_de;
  logic        menu_req, core_req;
  logic [2:0]  menu_slot, core_slot;
  logic        menu_ack, core_ack;
  logic [23:0] pck_rgb;
  logic        pck_vs, pck_hs, pck_de;
  logic [2:0]  cur_slot;
  logic        busy;

  typedef struct {
    logic [23:0] rgb;
    logic        de, vs, hs, mack, cack;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  jtframe_pocket_slot #(.BLANK_DLY(BLANK_DLY), .DEF_SLOT(DEF_SLOT)) dut (
    .clk(clk), .rst_n(rst_n), .pix_cen(pix_cen),
    .vid_rgb(vid_rgb), .vid_vs(vid_vs), .vid_hs(vid_hs), .vid_de(vid_de),
    .menu_req(menu_req), .menu_slot(menu_slot),
    .core_req(core_req), .core_slot(core_slot),
    .menu_ack(menu_ack), .core_ack(core_ack),
    .pck_rgb(pck_rgb), .pck_vs(pck_vs), .pck_hs(pck_hs), .pck_de(pck_de),
    .cur_slot(cur_slot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({pck_rgb, pck_de, pck_vs, pck_hs, menu_ack, core_ack});
  endfunction

  function automatic logic [31:0] pack_exp(input exp_t e);
    return 32'({e.rgb, e.de, e.vs, e.hs, e.mack, e.cack});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 pass-through, 1 menu command, 2 core command, 3 command without ack
  task automatic pix(input logic vs, input logic hs, input logic de, input int kind,
                     input logic [2:0] slot, input string tag);
    exp_t e;
    logic [23:0] rgb;
    rgb = 24'($urandom);
    vid_rgb = rgb; vid_vs = vs; vid_hs = hs; vid_de = de; pix_cen = 1'b1;
    e.rgb  = (kind != 0) ? {13'd0, slot, 8'd0} : rgb;
    e.de   = (kind != 0) ? 1'b0 : de;
    e.vs   = vs;
    e.hs   = hs;
    e.mack = (kind == 1);
    e.cack = (kind == 2);
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    chk({tag, "_pix"}, pack_out(), pack_exp(e));
    if (kind != 0) chk({tag, "_cur_slot"}, 32'(cur_slot), 32'(slot));
    if (kind == 1) menu_req = 1'b0;
    if (kind == 2) core_req = 1'b0;
    pix_cen = 1'b0;
    tick();
    e.mack = 1'b0;
    e.cack = 1'b0;
    chk({tag, "_hold"}, pack_out(), pack_exp(e));
  endtask

  task automatic frame(input int nblank, input int nact, input int ckind,
                       input logic [2:0] cslot, input string tag);
    pix(1'b1, 1'b1, 1'b0, 0, 3'd0, {tag, "_vs"});
    for (int i = 0; i < nblank; i++)
      pix(1'b0, (i == 0), 1'b0, (ckind != 0 && i == int'(BLANK_DLY)) ? ckind : 0, cslot,
          {tag, "_blank"});
    for (int i = 0; i < nact; i++)
      pix(1'b0, 1'b0, 1'b1, 0, 3'd0, {tag, "_act"});
  endtask

  initial begin
    rst_n = 1'b0; pix_cen = 1'b0; vid_rgb = '0; vid_vs = 1'b0; vid_hs = 1'b0; vid_de = 1'b0;
    menu_req = 1'b0; core_req = 1'b0; menu_slot = '0; core_slot = '0;

    // Reset holds outputs low even with live video
    for (int i = 0; i < 4; i++) begin
      vid_rgb = 24'($urandom); vid_de = 1'b1; vid_hs = 1'b1; pix_cen = (i % 2 == 0);
      tick();
    end
    chk("rst_out", pack_out(), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_slot", 32'(cur_slot), 32'(DEF_SLOT));
    pix_cen = 1'b0;
    rst_n = 1'b1;
    tick();

    frame(4, 3, IDLE_K, DEF_SLOT, "idle0");
    chk("idle0_busy", 32'(busy), 32'd0);

    // Single core request
    core_slot = 3'd5; core_req = 1'b1;
    tick();
    chk("core_busy", 32'(busy), 32'd1);
    frame(4, 3, 2, 3'd5, "core5");
    chk("core5_busy", 32'(busy), 32'd0);

    // Simultaneous requests: menu first, core the next frame
    menu_slot = 3'd2; core_slot = 3'd6; menu_req = 1'b1; core_req = 1'b1;
    tick();
    frame(4, 3, 1, 3'd2, "tie_menu");
    chk("tie_core_pending", 32'(busy), 32'd1);
    frame(4, 3, 2, 3'd6, "tie_core");

    // DE returns before the blanking count completes
    core_slot = 3'd4; core_req = 1'b1;
    tick();
    frame(1, 3, 0, 3'd0, "early_de");
    chk("early_de_busy", 32'(busy), 32'd1);
    chk("early_de_slot", 32'(cur_slot), 32'd6);
    frame(4, 3, 2, 3'd4, "retry");

    // Request withdrawn while waiting for blanking
    core_slot = 3'd7; core_req = 1'b1;
    tick();
    pix(1'b1, 1'b1, 1'b0, 0, 3'd0, "cancel_vs");
    pix(1'b0, 1'b1, 1'b0, 0, 3'd0, "cancel_b0");
    core_req = 1'b0;
    tick();
    chk("cancel_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, 1'b0, 0, 3'd0, "cancel_blank");
    pix(1'b0, 1'b0, 1'b1, 0, 3'd0, "cancel_act");
    chk("cancel_slot", 32'(cur_slot), 32'd4);
    chk("cancel_ack", 32'({menu_ack, core_ack}), 32'd0);

    // Reset in the middle of a pending request's blanking window
    core_slot = 3'd5; core_req = 1'b1;
    tick();
    pix(1'b1, 1'b1, 1'b0, 0, 3'd0, "mrst_vs");
    pix(1'b0, 1'b1, 1'b0, 0, 3'd0, "mrst_b0");
    rst_n = 1'b0;
    #1;
    chk("mrst_out", pack_out(), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_slot", 32'(cur_slot), 32'(DEF_SLOT));
    pix_cen = 1'b1; vid_de = 1'b0;
    tick();
    chk("mrst_hold_out", pack_out(), 32'd0);
    pix_cen = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pix(1'b0, 1'b0, 1'b0, 0, 3'd0, "mrst_rest");
    pix(1'b0, 1'b0, 1'b1, 0, 3'd0, "mrst_act");
    chk("mrst_rest_slot", 32'(cur_slot), 32'(DEF_SLOT));
    frame(4, 3, 2, 3'd5, "mrst_send");

    // Idle frames after everything settles
    frame(4, 2, IDLE_K, 3'd5, "idle1");
    frame(4, 2, IDLE_K, 3'd5, "idle2");
    chk("final_slot", 32'(cur_slot), 32'd5);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
